// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_t      : controller state encoding (RUN / MD_BUSY)
//   DEF_*_LAT    : default multiply / divide freeze lengths in cycles
//   CNT_W        : width of the multiply/divide latency counter
//   md_load_val  : value loaded into the latency counter on accept
package pipe_ctrl_pkg;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_BUSY = 1'b1
  } state_t;

  localparam int DEF_MUL_LAT = 4;
  localparam int DEF_DIV_LAT = 32;

  localparam int CNT_W   = 6;
  localparam int STALL_W = 16;
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  // The accept cycle is itself a freeze cycle, so the counter starts at
  // LAT-1 and the operation freezes for LAT cycles in total.
  function automatic logic [CNT_W-1:0] md_load_val(input logic md_op,
                                                   input int   mul_lat,
                                                   input int   div_lat);
    logic [CNT_W-1:0] v;
    if (md_op) v = CNT_W'(div_lat - 1);
    else       v = CNT_W'(mul_lat - 1);
    return v;
  endfunction

endpackage

// File: rtl/pipe_ctrl_ff_lib.sv
// Flip-flop library used by the pipeline controller.
//   dffr  : W-bit register, synchronous active-high reset to zero
//   dffre : W-bit register with enable, synchronous active-high reset to zero
// Ports: clk, r (reset), en (dffre only), d, q.
module dffr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         r,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (r) q <= '0;
    else   q <= d;
  end
endmodule

module dffre #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         r,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (r)       q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/pipe_hazard_ctrl_md_lat_counter.sv
// Multiply/divide latency down-counter.
//   clk, r       : clock and synchronous active-high reset (count -> 0)
//   i_load       : load i_load_val (has priority over decrement)
//   i_load_val   : value to load
//   i_dec        : decrement by one; holds at zero instead of wrapping
//   o_zero       : count is zero
module md_lat_counter
  import pipe_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             r,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_cnt_en;

  always_comb begin
    w_cnt_en   = i_load | (i_dec & ~o_zero);
    w_cnt_next = i_load ? i_load_val : (r_cnt - CNT_W'(1));
  end

  dffre #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .r   (r),
    .en  (w_cnt_en),
    .d   (w_cnt_next),
    .q   (r_cnt)
  );

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubble insertion, branch flush and
// multi-cycle multiply/divide freeze for a classic 5-stage pipeline.
// Parameters:
//   MUL_LAT, DIV_LAT : total freeze cycles for mul / div (legal 2..63)
// Ports:
//   clk, r                       : clock, synchronous active-high reset
//   id_rs, id_rt, id_*_used      : source registers read by the ID instruction
//   ex_rd, ex_regwrite, ex_is_load : destination / type of the EX instruction
//   br_taken                     : taken branch/jump resolved in EX
//   md_start, md_op              : mul (0) / div (1) issue from EX
//   pc_en, ifid_en, ifid_r, idex_en, idex_r, exmem_r : pipeline register controls
//   md_busy, md_done             : freeze indicator, one-cycle completion pulse
//   stall_cycles                 : saturating count of cycles with pc_en=0
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input  logic        clk,
  input  logic        r,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_rs_used,
  input  logic        id_rt_used,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwrite,
  input  logic        ex_is_load,
  input  logic        br_taken,
  input  logic        md_start,
  input  logic        md_op,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_r,
  output logic        idex_en,
  output logic        idex_r,
  output logic        exmem_r,
  output logic        md_busy,
  output logic        md_done,
  output logic [15:0] stall_cycles
);

  logic                r_state_bit;
  state_t              r_state;
  state_t              w_state_next;
  logic                w_cnt_zero;
  logic                w_load_use;
  logic                w_accept;
  logic                w_busy_frz;
  logic                w_md_fin;
  logic                w_freeze;
  logic [STALL_W-1:0]  r_stall_cycles;

  // ---------------------------------------------------------------------
  // Hazard decode
  // ---------------------------------------------------------------------
  assign w_load_use = ex_is_load & ex_regwrite & (ex_rd != 5'd0) &
                      ((id_rs_used & (id_rs == ex_rd)) |
                       (id_rt_used & (id_rt == ex_rd)));

  // A taken branch squashes the issuing mul/div, so it is never accepted.
  assign w_accept   = (r_state == ST_RUN) & md_start & ~br_taken;
  // Busy cycles freeze while the count is non-zero; the zero cycle is the
  // completion cycle and runs normally.
  assign w_busy_frz = (r_state == ST_MD_BUSY) & ~w_cnt_zero;
  assign w_md_fin   = (r_state == ST_MD_BUSY) &  w_cnt_zero;
  assign w_freeze   = w_accept | w_busy_frz;

  // ---------------------------------------------------------------------
  // State register and latency counter
  // ---------------------------------------------------------------------
  dffr #(.W(1)) u_state (
    .clk (clk),
    .r   (r),
    .d   (w_state_next),
    .q   (r_state_bit)
  );

  assign r_state = state_t'(r_state_bit);

  md_lat_counter u_md_cnt (
    .clk        (clk),
    .r          (r),
    .i_load     (w_accept),
    .i_load_val (md_load_val(md_op, MUL_LAT, DIV_LAT)),
    .i_dec      (r_state == ST_MD_BUSY),
    .o_zero     (w_cnt_zero)
  );

  // ---------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    ifid_r       = 1'b0;
    idex_r       = 1'b0;
    exmem_r      = 1'b0;
    md_busy      = 1'b0;
    md_done      = 1'b0;

    case (r_state)
      ST_RUN:     if (w_accept) w_state_next = ST_MD_BUSY;
      ST_MD_BUSY: if (w_md_fin) w_state_next = ST_RUN;
      default:    w_state_next = ST_RUN;
    endcase

    if (r) begin
      // Hold the whole pipe in reset and keep the PC still.
      pc_en   = 1'b0;
      ifid_r  = 1'b1;
      idex_r  = 1'b1;
      exmem_r = 1'b1;
    end else if (w_freeze) begin
      // Freeze fetch/decode/execute; EX/MEM receives bubbles.
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      idex_en = 1'b0;
      exmem_r = 1'b1;
      md_busy = 1'b1;
    end else if (w_md_fin) begin
      md_done = 1'b1;
    end else if ((r_state == ST_RUN) && br_taken) begin
      ifid_r  = 1'b1;
      idex_r  = 1'b1;
    end else if ((r_state == ST_RUN) && w_load_use) begin
      // Hold PC and IF/ID, inject a bubble into ID/EX.
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      idex_r  = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Stall cycle counter (saturating)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (r) begin
      r_stall_cycles <= '0;
    end else if (!pc_en && (r_stall_cycles != STALL_MAX)) begin
      r_stall_cycles <= r_stall_cycles + STALL_W'(1);
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// stimulus, all compared cycle by cycle against a behavioural model that
// tracks the completion cycle of an in-flight mul/div as an absolute time.
module tb_pipe_hazard_ctrl;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  logic        clk = 1'b0;
  logic        r = 1'b1;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_rd = '0;
  logic        id_rs_used = 1'b0, id_rt_used = 1'b0;
  logic        ex_regwrite = 1'b0, ex_is_load = 1'b0;
  logic        br_taken = 1'b0, md_start = 1'b0, md_op = 1'b0;
  logic        pc_en, ifid_en, ifid_r, idex_en, idex_r, exmem_r, md_busy, md_done;
  logic [15:0] stall_cycles;

  int     n_checks = 0;
  int     n_fail   = 0;
  int     m_cyc    = 0;
  longint m_done   = -1;
  int     m_stall  = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk          (clk),
    .r            (r),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rs_used   (id_rs_used),
    .id_rt_used   (id_rt_used),
    .ex_rd        (ex_rd),
    .ex_regwrite  (ex_regwrite),
    .ex_is_load   (ex_is_load),
    .br_taken     (br_taken),
    .md_start     (md_start),
    .md_op        (md_op),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .ifid_r       (ifid_r),
    .idex_en      (idex_en),
    .idex_r       (idex_r),
    .exmem_r      (exmem_r),
    .md_busy      (md_busy),
    .md_done      (md_done),
    .stall_cycles (stall_cycles)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d, t=%0t)", tag, got, exp, m_cyc, $time);
    end
  endtask

  task automatic set_idle();
    r = 1'b0; id_rs = '0; id_rt = '0; ex_rd = '0;
    id_rs_used = 1'b0; id_rt_used = 1'b0; ex_regwrite = 1'b0; ex_is_load = 1'b0;
    br_taken = 1'b0; md_start = 1'b0; md_op = 1'b0;
  endtask

  // One clock cycle: predict, sample at negedge, advance the model.
  task automatic tick();
    logic lu, busy, acc;
    logic e_pc, e_ifen, e_ifr, e_iden, e_idr, e_exr, e_busy, e_done;
    lu = ex_is_load && ex_regwrite && (ex_rd != 0) &&
         ((id_rs_used && id_rs == ex_rd) || (id_rt_used && id_rt == ex_rd));
    busy = (m_done >= 0) && (longint'(m_cyc) <= m_done);
    acc  = 1'b0;
    {e_pc, e_ifen, e_iden, e_ifr, e_idr, e_exr, e_busy, e_done} = 8'b1110_0000;
    if (r) begin
      {e_pc, e_ifen, e_iden, e_ifr, e_idr, e_exr} = 6'b011_111;
    end else if (busy && longint'(m_cyc) < m_done) begin
      {e_pc, e_ifen, e_iden, e_exr, e_busy} = 5'b000_11;
    end else if (busy) begin
      e_done = 1'b1;
    end else if (md_start && !br_taken) begin
      {e_pc, e_ifen, e_iden, e_exr, e_busy} = 5'b000_11;
      acc = 1'b1;
    end else if (br_taken) begin
      {e_ifr, e_idr} = 2'b11;
    end else if (lu) begin
      {e_pc, e_ifen, e_iden, e_idr} = 4'b0011;
    end
    @(negedge clk);
    check_eq("pc_en",   pc_en,   e_pc);
    check_eq("ifid_en", ifid_en, e_ifen);
    check_eq("ifid_r",  ifid_r,  e_ifr);
    check_eq("idex_en", idex_en, e_iden);
    check_eq("idex_r",  idex_r,  e_idr);
    check_eq("exmem_r", exmem_r, e_exr);
    check_eq("md_busy", md_busy, e_busy);
    check_eq("md_done", md_done, e_done);
    check_eq("stall_cycles", stall_cycles, m_stall);
    if (r) begin
      m_done  = -1;
      m_stall = 0;
    end else begin
      if (acc) m_done = m_cyc + (md_op ? DIV_LAT : MUL_LAT);
      if (!e_pc && m_stall < 65535) m_stall++;
    end
    m_cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;

    // Reset
    r = 1'b1; tick(); tick();
    set_idle();
    check_eq("rst_stall", stall_cycles, 16'd0);
    $display("[tb] reset done, stall_cycles=%0d", stall_cycles);

    // Load-use on rs: exactly one bubble
    ex_is_load = 1; ex_regwrite = 1; ex_rd = 5'd5; id_rs = 5'd5; id_rs_used = 1;
    tick();
    set_idle(); tick();
    check_eq("lu_stall", stall_cycles, 16'd1);
    $display("[tb] load-use r5 -> stall_cycles=%0d", stall_cycles);

    // Same case with ex_rd=0, then with id_rs_used=0: no stall
    ex_is_load = 1; ex_regwrite = 1; ex_rd = 5'd0; id_rs = 5'd0; id_rs_used = 1;
    tick();
    ex_rd = 5'd5; id_rs = 5'd5; id_rs_used = 0;
    tick();
    set_idle(); tick();
    check_eq("lu_none_stall", stall_cycles, 16'd1);
    $display("[tb] load-use masked cases -> stall_cycles=%0d", stall_cycles);

    // Multiply: freeze 4 cycles, done on the 5th
    md_start = 1; md_op = 0; tick();
    set_idle(); repeat (6) tick();
    check_eq("mul_stall", stall_cycles, 16'd5);
    $display("[tb] multiply -> stall_cycles=%0d", stall_cycles);

    // Divide: freeze 32 cycles, done on the 33rd
    md_start = 1; md_op = 1; tick();
    set_idle(); repeat (34) tick();
    check_eq("div_stall", stall_cycles, 16'd37);
    $display("[tb] divide -> stall_cycles=%0d", stall_cycles);

    // Branch together with load-use, then branch together with md_start
    br_taken = 1; ex_is_load = 1; ex_regwrite = 1; ex_rd = 5'd7; id_rt = 5'd7; id_rt_used = 1;
    tick();
    set_idle(); br_taken = 1; md_start = 1; md_op = 1;
    tick();
    set_idle(); repeat (3) tick();
    check_eq("br_stall", stall_cycles, 16'd37);
    $display("[tb] branch priority -> stall_cycles=%0d", stall_cycles);

    // Reset in cycle 2 of a divide, then a clean multiply
    md_start = 1; md_op = 1; tick();
    set_idle(); tick();
    r = 1; tick();
    set_idle();
    check_eq("abort_stall", stall_cycles, 16'd0);
    repeat (40) tick();
    md_start = 1; md_op = 0; tick();
    set_idle(); repeat (6) tick();
    check_eq("post_abort_stall", stall_cycles, 16'd4);
    $display("[tb] divide aborted by reset, new multiply -> stall_cycles=%0d", stall_cycles);

    // Random mix
    for (int i = 0; i < 3000; i++) begin
      r           = ($urandom_range(0, 63) == 0);
      id_rs       = 5'($urandom_range(0, 7));
      id_rt       = 5'($urandom_range(0, 7));
      ex_rd       = 5'($urandom_range(0, 7));
      id_rs_used  = 1'($urandom_range(0, 1));
      id_rt_used  = 1'($urandom_range(0, 1));
      ex_regwrite = 1'($urandom_range(0, 1));
      ex_is_load  = 1'($urandom_range(0, 1));
      br_taken    = ($urandom_range(0, 3) == 0);
      md_start    = ($urandom_range(0, 7) == 0);
      md_op       = 1'($urandom_range(0, 1));
      tick();
    end
    set_idle();
    $display("[tb] random phase done, stall_cycles=%0d", stall_cycles);

    // Saturation through back-to-back divides
    r = 1; tick();
    set_idle();
    for (int i = 0; i < 80000 && m_stall < 65535; i++) begin
      md_start   = 1; md_op = 1;
      br_taken   = ($urandom_range(0, 31) == 0);
      ex_is_load = 1'($urandom_range(0, 1));
      ex_regwrite = 1'($urandom_range(0, 1));
      ex_rd      = 5'($urandom_range(0, 3));
      id_rs      = 5'($urandom_range(0, 3));
      id_rs_used = 1'($urandom_range(0, 1));
      tick();
    end
    check_eq("sat_reached", (m_stall == 65535) ? 32'd1 : 32'd0, 32'd1);
    repeat (100) tick();
    set_idle(); tick();
    check_eq("sat_hold", stall_cycles, 16'hFFFF);
    $display("[tb] saturation phase done, stall_cycles=%0h", stall_cycles);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
